// File: rtl/cpu_reg_file_pkg.sv
// Shared CPU package.
// Holds the register-file geometry (data width, address width, register
// count) and the word/address types used across the small CPU datapath.
package cpu_reg_file_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int OUT_REG  = 0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/cpu_reg_file.sv
// cpu_reg_file
// 16 x 8-bit general-purpose register file for the small CPU datapath.
// Two combinational read ports feed the ALU operands, one synchronous write
// port stores the ALU result, and register OUT_REG (R0 by default) is
// mirrored continuously on cpu_out as the CPU output register.
//
// Ports:
//   clk          - single clock, all state changes on the rising edge
//   RESET        - synchronous, active-low; clears every register
//   RA1, RA2     - read addresses for ports 1 and 2
//   WA           - write address
//   ALUResult    - write data
//   write_enable - active-high write strobe
//   RD1, RD2     - contents of reg[RA1], reg[RA2] (zero latency)
//   cpu_out      - contents of reg[OUT_REG]
module cpu_reg_file #(
  parameter int DATA_W  = cpu_reg_file_pkg::DATA_W,
  parameter int ADDR_W  = cpu_reg_file_pkg::ADDR_W,
  parameter int OUT_REG = cpu_reg_file_pkg::OUT_REG
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic              write_enable,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] cpu_out
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] OUT_IDX = ADDR_W'(OUT_REG);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage: reset wins over a simultaneous write; otherwise only the
  // addressed register is loaded when the strobe is high.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_enable) begin
      regs[WA] <= ALUResult;
    end
  end

  // Reads have no write-through bypass: a read of the register being
  // written shows the old value until the edge has passed.
  assign RD1     = regs[RA1];
  assign RD2     = regs[RA2];
  assign cpu_out = regs[OUT_IDX];

endmodule

// File: tb/tb_cpu_reg_file.sv
// Self-checking bench for cpu_reg_file: directed steps followed by a
// randomized phase compared against a simple array model of the registers.
module tb_cpu_reg_file;

  logic       clk;
  logic       RESET;
  logic [3:0] RA1, RA2, WA;
  logic [7:0] ALUResult;
  logic       write_enable;
  logic [7:0] RD1, RD2, cpu_out;

  int compared;
  int mismatched;

  // Reference model: plain array of register contents.
  logic [7:0] model [16];

  cpu_reg_file dut (
    .clk          (clk),
    .RESET        (RESET),
    .RA1          (RA1),
    .RA2          (RA2),
    .WA           (WA),
    .ALUResult    (ALUResult),
    .write_enable (write_enable),
    .RD1          (RD1),
    .RD2          (RD2),
    .cpu_out      (cpu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge; the model applies the register-file rules to the
  // inputs present at that edge, then outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (RESET === 1'b0) begin
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
    end else if (write_enable === 1'b1) begin
      model[WA] = ALUResult;
    end
    #1;
  endtask

  task automatic checkModel(input string tag);
    check({tag, "_rd1"}, RD1, model[RA1]);
    check({tag, "_rd2"}, RD2, model[RA2]);
    check({tag, "_out"}, cpu_out, model[0]);
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    RESET        = 1'b1;
    RA1          = 4'd0;
    RA2          = 4'd0;
    WA           = 4'd0;
    ALUResult    = 8'd0;
    write_enable = 1'b0;
    #2;

    // 1: reset clears everything
    RESET = 1'b0; RA1 = 4'd1; RA2 = 4'd2;
    tick();
    check("rst_rd1", RD1, 8'd0);
    check("rst_rd2", RD2, 8'd0);
    check("rst_out", cpu_out, 8'd0);
    for (int i = 0; i < 16; i++) begin
      RA1 = 4'(i);
      #1;
      check($sformatf("rst_r%0d", i), RD1, 8'd0);
    end
    RA1 = 4'd1;

    // 2: write R0 shows on cpu_out, R1 untouched
    RESET = 1'b1; WA = 4'd0; ALUResult = 8'd5; write_enable = 1'b1;
    tick();
    check("w0_out", cpu_out, 8'd5);
    check("w0_rd1", RD1, 8'd0);

    // 3: write R1 and R5
    WA = 4'd1; ALUResult = 8'd7;
    tick();
    check("w1_rd1", RD1, 8'd7);
    WA = 4'd5; ALUResult = 8'd13;
    tick();
    RA2 = 4'd5;
    #1;
    check("w5_rd2", RD2, 8'd13);
    check("w5_out", cpu_out, 8'd5);

    // 4: write_enable low blocks writes
    write_enable = 1'b0; WA = 4'd1; ALUResult = 8'd99;
    repeat (3) tick();
    check("we0_rd1", RD1, 8'd7);
    check("we0_rd2", RD2, 8'd13);
    check("we0_out", cpu_out, 8'd5);

    // 5: read-during-write returns old value until the edge
    RA1 = 4'd3; WA = 4'd3; ALUResult = 8'd42; write_enable = 1'b1;
    #1;
    check("rdw_old", RD1, 8'd0);
    tick();
    check("rdw_new", RD1, 8'd42);

    // RA1 == RA2 both return the same register
    RA2 = 4'd3;
    #1;
    check("same_rd2", RD2, 8'd42);

    // 6: reset has priority over a simultaneous write
    RESET = 1'b0; write_enable = 1'b1; WA = 4'd2; ALUResult = 8'hA5;
    tick();
    RESET = 1'b1; write_enable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      RA1 = 4'(i);
      #1;
      check($sformatf("rstpri_r%0d", i), RD1, 8'd0);
    end
    check("rstpri_out", cpu_out, 8'd0);

    // Randomized phase against the model
    for (int n = 0; n < 300; n++) begin
      RESET        = ($urandom_range(0, 29) != 0);
      write_enable = ($urandom_range(0, 3) != 0);
      WA           = 4'($urandom_range(0, 15));
      ALUResult    = 8'($urandom);
      RA1          = ($urandom_range(0, 3) == 0) ? WA : 4'($urandom_range(0, 15));
      RA2          = ($urandom_range(0, 3) == 0) ? RA1 : 4'($urandom_range(0, 15));
      #1;
      checkModel("rnd_pre");
      tick();
      checkModel("rnd_post");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
